// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues 1-cycle-latency imem reads, buffers words in a prefetch queue.
// Optional self-halt on halt-encoded words is enabled with `define FETCH_HALT_EN.
module instr_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_next,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a word transfers on a cycle where out_valid && out_ready; the head
  // (out_instr/out_pc/out_pc_next) is held stable while out_valid=1 and out_ready=0.

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              kill_q, kill_d;
  logic              halted_q, halted_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];

  logic [CNT_W:0] credits_used;
  logic           issue;
  logic           push;
  logic           pop;
  logic           halt_push;

  // The in-flight read consumes a queue slot so a returning word always has room.
  assign credits_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign issue        = rst_n && !redirect_valid && !halted_q
                        && (credits_used < (CNT_W+1)'(DEPTH));
  assign push         = inflight_q && !kill_q && !redirect_valid;
  assign pop          = out_valid && out_ready && !redirect_valid;

`ifdef FETCH_HALT_EN
  assign halt_push = push && (imem_rdata[31:30] == 2'b11) && (imem_rdata[29:26] != 4'b0000);
`else
  assign halt_push = 1'b0;
`endif

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    kill_d        = halt_push && issue;
    halted_d      = halted_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
    if (issue) begin
      pc_d          = pc_q + 1'b1;
      inflight_pc_d = pc_q;
    end
    if (halt_push) halted_d = 1'b1;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    if (redirect_valid) begin
      pc_d     = redirect_pc;
      halted_d = 1'b0;
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= ADDR_W'(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
      halted_q      <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
      halted_q      <= halted_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  // Payload storage needs no reset; count_q alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_q] <= imem_rdata;
      pc_mem[tail_q]    <= inflight_pc_q;
    end
  end

  assign imem_en     = issue;
  assign imem_addr   = pc_q;
  assign out_valid   = (count_q != '0);
  assign out_instr   = instr_mem[head_q];
  assign out_pc      = pc_mem[head_q];
  assign out_pc_next = pc_mem[head_q] + 1'b1;
  assign halted      = halted_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of decode/execute.
- Owns the 8-bit program counter and issues reads to the 32x256 synchronous instruction memory (1-cycle read latency).
- Buffers returned words in a small prefetch queue and hands {instruction, pc} to decode over a valid/ready handshake.
- Decode/execute redirects fetch for taken branches, jumps, calls and returns.

Parameters:
- ADDR_W, 8, instruction-memory address / PC width
- DATA_W, 32, instruction width
- DEPTH, 4, prefetch queue entries (power of 2, >=2)
- RESET_PC, 0, PC value loaded at reset

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_en  out  1  read strobe to instruction memory
- imem_addr  out  ADDR_W  read address, valid when imem_en=1
- imem_rdata  in  DATA_W  read data, valid the cycle after imem_en=1
- out_valid  out  1  queue head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  DATA_W  head instruction word
- out_pc  out  ADDR_W  address of head instruction
- out_pc_next  out  ADDR_W  out_pc+1 mod 2^ADDR_W, used as the $ra value for call
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  ADDR_W  new fetch address
- halted  out  1  fetch stopped on halt (0 when feature compiled out)

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: pc=RESET_PC, queue empty (count=0), in-flight flag=0, out_valid=0, imem_en=0, halted=0. Outputs are held at these values for as long as rst_n=0.
- Issue (imem_en, combinational): imem_en=1 when !redirect_valid && !halted && (count + inflight) < DEPTH. Then imem_addr=pc, and pc<=pc+1 at the edge.
- PC wraps 8'hFF -> 8'h00. No error is raised on wrap.
- Return: in-flight flag <= imem_en, with the issued address latched alongside. The next cycle, {imem_rdata, latched pc} is pushed at the queue tail unless a kill is pending.
- Latency: issue in cycle N, push at end of N+1, out_valid=1 in N+2. Sustains 1 instr/cycle while out_ready=1.
- Handshake:
  - Pop when out_valid && out_ready.
  - out_instr/out_pc/out_pc_next hold stable while out_valid=1 and out_ready=0.
  - Never overflow: the credit rule counts the in-flight read.
  - Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority):
  - On redirect_valid=1: queue is flushed, pop is ignored, no issue that cycle, pc<=redirect_pc, halted<=0.
  - Any read in flight during that cycle, or issued in the cycle before, is killed and its data discarded.
  - out_valid=0 in the next cycle. Fetch resumes at redirect_pc the cycle after redirect.
  - Back-to-back redirects: last one wins.
- Full queue: issue stalls. Issue resumes in the cycle after a pop brings count+inflight below DEPTH.
- Empty queue with out_ready=1: out_valid=0, no pop.
- Reset mid-operation: all state returns to reset values immediately. In-flight data arriving after release is dropped.
- Queue: circular buffer, head/tail pointers log2(DEPTH) bits, count 0..DEPTH.

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined:
  - A returned word whose op field instr[31:30]=2'b11 and fn field instr[29:26]!=4'b0000 is a halt.
  - The halt word is enqueued normally. halted<=1 on the same edge, and a read issued alongside it is killed.
  - No further issue until redirect_valid or reset. halted stays 1 while the queue drains.
- Undefined: halted is tied to 0. Every word is treated as ordinary and fetch never self-stops.

Test Plan:
- Reset release, imem returns mem[k]=32'h1000_0000+k, out_ready=1: imem_addr 0,1,2,... one per cycle. First out_valid 2 cycles after first imem_en with out_pc=0, out_instr=32'h1000_0000. Then one instruction per cycle.
- out_ready=0 from reset: exactly 4 reads issued (addr 0..3), then imem_en=0. Head stays pc=0. Raise out_ready: pops pcs 0,1,2,3,4 in order with no gaps after the first.
- Redirect to 8'h40 while queue holds pcs 5..7 and pc 8 is in flight: next cycle out_valid=0. Next imem_addr=8'h40. First delivered out_pc=8'h40; pcs 5..8 are never delivered.
- Redirect to 8'hFE: delivers pcs FE, FF, 00, 01. out_pc_next at FF = 8'h00.
- rst_n pulsed low mid-stream, async to clk: out_valid and imem_en drop with no clock edge needed. After release, fetch restarts at pc 0 and no stale word appears.
- FETCH_HALT_EN, mem[3]=32'hC400_0000: pcs 0..3 delivered, halted=1, imem_en stays 0. Redirect to 8'h10 clears halted and fetches pc 16. Without macro: pcs 4,5,... continue and halted=0.
